// File: rtl/timer_pkg.sv
// Shared constants, FSM state encoding and prescaler limit decode for the timer counter.
package timer_pkg;
    localparam int CNT_W   = 64;
    localparam int DIV_MAX = 8;
    localparam int DIV_W   = 4;
    localparam int PRE_W   = DIV_MAX;

    typedef logic [1:0] state_t;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    // Exponents above DIV_MAX saturate because only PRE_W bits can ever be set.
    function automatic logic [PRE_W-1:0] div_limit(input logic en, input logic [DIV_W-1:0] val);
        logic [PRE_W-1:0] lim;
        lim = '0;
        if (en) begin
            for (int i = 0; i < PRE_W; i++) begin
                if (i < int'(val)) lim[i] = 1'b1;
            end
        end
        return lim;
    endfunction
endpackage

// File: rtl/timer_counter_if.sv
// Register-file side bundle for the timer counter: control strobes in, count and status out.
interface timer_counter_if;
    import timer_pkg::*;

    logic             timer_en;
    logic             div_en;
    logic [DIV_W-1:0] div_val;
    logic             cnt_lo_we;
    logic             cnt_hi_we;
    logic [31:0]      wdata;
    logic             dbg_mode;
    logic             halt_req;
    logic             halt_ack;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_ovf;

    modport master (
        output timer_en, div_en, div_val, cnt_lo_we, cnt_hi_we, wdata, dbg_mode, halt_req,
        input  halt_ack, cnt_val, cnt_ovf
    );

    modport slave (
        input  timer_en, div_en, div_val, cnt_lo_we, cnt_hi_we, wdata, dbg_mode, halt_req,
        output halt_ack, cnt_val, cnt_ovf
    );
endinterface

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: counts run cycles and emits a one-cycle tick every limit+1 of them.
module timer_prescaler
    import timer_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             run,
    input  logic             clear,
    output logic             tick
);
    logic [PRE_W-1:0] div_cnt_q, div_cnt_d;
    logic [PRE_W-1:0] limit;
    logic             div_en_q, div_en_d;
    logic [DIV_W-1:0] div_val_q, div_val_d;
    logic             change;

    always_comb begin
        limit     = div_limit(div_en, div_val);
        change    = (div_en != div_en_q) || (div_val != div_val_q);
        div_en_d  = div_en;
        div_val_d = div_val;
        // A restart of the prescale window (clear or setting change) swallows any due tick.
        tick      = run && !clear && !change && (div_cnt_q == limit);
        div_cnt_d = div_cnt_q;
        if (clear || change) begin
            div_cnt_d = '0;
        end else if (run) begin
            div_cnt_d = tick ? '0 : div_cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt_q <= '0;
            div_en_q  <= 1'b0;
            div_val_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            div_en_q  <= div_en_d;
            div_val_q <= div_val_d;
        end
    end
endmodule

// File: rtl/timer_counter.sv
// 64-bit free-running timer with prescaler, software load and debug halt.
// Debug halt is built only when TIMER_CNT_HALT_EN is defined.
module timer_counter
    import timer_pkg::*;
(
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    timer_counter_if.slave  bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_val_q, cnt_val_d;
    logic             cnt_ovf_q, cnt_ovf_d;
    logic             halt_ack_q, halt_ack_d;
    logic             halt_cond;
    logic             load;
    logic             run;
    logic             clear;
    logic             tick;

`ifdef TIMER_CNT_HALT_EN
    assign halt_cond = bus.dbg_mode & bus.halt_req;
`else
    logic unused_halt;
    assign unused_halt = bus.dbg_mode ^ bus.halt_req;
    assign halt_cond   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.timer_en) state_d = COUNT;
            COUNT: begin
                if (!bus.timer_en)  state_d = IDLE;
                else if (halt_cond) state_d = HALT;
            end
`ifdef TIMER_CNT_HALT_EN
            HALT:    if (!halt_cond) state_d = bus.timer_en ? COUNT : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Only cycles that stay in COUNT advance the prescaler, so leaving COUNT drops a due tick.
    assign run   = (state_q == COUNT) && (state_d == COUNT);
    assign load  = bus.cnt_lo_we | bus.cnt_hi_we;
    assign clear = (state_q == IDLE) || load;

    timer_prescaler u_prescaler (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .div_en    (bus.div_en),
        .div_val   (bus.div_val),
        .run       (run),
        .clear     (clear),
        .tick      (tick)
    );

    always_comb begin
        cnt_val_d = cnt_val_q;
        cnt_ovf_d = 1'b0;
        if (load) begin
            if (bus.cnt_hi_we) cnt_val_d[CNT_W-1:32] = bus.wdata;
            if (bus.cnt_lo_we) cnt_val_d[31:0]       = bus.wdata;
        end else if (tick) begin
            cnt_val_d = cnt_val_q + CNT_W'(1);
            cnt_ovf_d = &cnt_val_q;
        end
`ifdef TIMER_CNT_HALT_EN
        halt_ack_d = (state_d == HALT);
`else
        halt_ack_d = 1'b0;
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            cnt_val_q  <= '0;
            cnt_ovf_q  <= 1'b0;
            halt_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_val_q  <= cnt_val_d;
            cnt_ovf_q  <= cnt_ovf_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    assign bus.cnt_val  = cnt_val_q;
    assign bus.cnt_ovf  = cnt_ovf_q;
    assign bus.halt_ack = halt_ack_q;
endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized traffic vs a reference model.
module tb_timer_counter;
    import timer_pkg::*;

`ifdef TIMER_CNT_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b1;
    int   n_checks  = 0;
    int   n_fail    = 0;

    timer_counter_if bus ();

    timer_counter dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Downstream compare stage: sticky interrupt when the count equals compare_val.
    logic        irq;
    logic        irq_clr = 1'b0;
    logic [63:0] compare_val = 64'd5;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                      irq <= 1'b0;
        else if (irq_clr)                    irq <= 1'b0;
        else if (bus.cnt_val == compare_val) irq <= 1'b1;
    end

    // Reference model: run state (0 stopped, 1 running, 2 halted), count and enabled-cycle phase.
    int          m_state;
    logic [63:0] m_cnt;
    int          m_phase;
    logic        m_ovf, m_ack, m_prev_en;
    logic [3:0]  m_prev_val;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = '0; m_phase = 0;
        m_ovf = 1'b0; m_ack = 1'b0; m_prev_en = 1'b0; m_prev_val = '0;
    endtask

    // Advance the model by the current inputs, clock the DUT once and compare all outputs.
    task automatic cycle();
        int  period, nxt;
        bit  halt, ld, chg, run, tk;
        halt   = HALT_EN && bus.dbg_mode && bus.halt_req;
        ld     = bus.cnt_lo_we || bus.cnt_hi_we;
        chg    = (bus.div_en != m_prev_en) || (bus.div_val != m_prev_val);
        period = bus.div_en ? (1 << ((bus.div_val > 4'd8) ? 8 : int'(bus.div_val))) : 1;
        if (m_state == 0)      nxt = bus.timer_en ? 1 : 0;
        else if (m_state == 1) nxt = !bus.timer_en ? 0 : (halt ? 2 : 1);
        else                   nxt = halt ? 2 : (bus.timer_en ? 1 : 0);
        run = (m_state == 1) && (nxt == 1);
        tk  = run && !ld && !chg && (m_phase == period - 1);
        m_ovf = tk && (m_cnt == 64'hFFFF_FFFF_FFFF_FFFF);
        if (bus.cnt_hi_we) m_cnt[63:32] = bus.wdata;
        if (bus.cnt_lo_we) m_cnt[31:0]  = bus.wdata;
        if (tk) m_cnt = m_cnt + 64'd1;
        if (m_state == 0 || ld || chg) m_phase = 0;
        else if (run)                  m_phase = (m_phase + 1) % period;
        m_ack      = (nxt == 2);
        m_state    = nxt;
        m_prev_en  = bus.div_en;
        m_prev_val = bus.div_val;
        @(posedge sys_clk);
        #1;
        check("cnt_val",  bus.cnt_val,  m_cnt);
        check("cnt_ovf",  bus.cnt_ovf,  m_ovf);
        check("halt_ack", bus.halt_ack, m_ack);
    endtask

    task automatic load(input logic lo, input logic hi, input logic [31:0] d);
        bus.cnt_lo_we = lo; bus.cnt_hi_we = hi; bus.wdata = d;
        cycle();
        bus.cnt_lo_we = 1'b0; bus.cnt_hi_we = 1'b0;
    endtask

    initial begin
        int halt_left;
        bus.timer_en = 0; bus.div_en = 0; bus.div_val = 0; bus.cnt_lo_we = 0;
        bus.cnt_hi_we = 0; bus.wdata = 0; bus.dbg_mode = 0; bus.halt_req = 0;
        model_reset();
        #1 sys_rst_n = 1'b0;
        #1;
        check("rst_cnt", bus.cnt_val, 64'd0);
        check("rst_ovf", bus.cnt_ovf, 64'd0);
        check("rst_ack", bus.halt_ack, 64'd0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk) sys_rst_n = 1'b1;

        // T1: increment every cycle, hold when disabled
        bus.timer_en = 1;
        cycle();
        check("t1_latency0", bus.cnt_val, 64'd0);
        cycle();
        check("t1_latency1", bus.cnt_val, 64'd1);
        repeat (9) cycle();
        check("t1_ten", bus.cnt_val, 64'd10);
        bus.timer_en = 0;
        repeat (3) cycle();
        check("t1_hold", bus.cnt_val, 64'd10);
        $display("T1 free-run count=%0d", bus.cnt_val);

        // T2: divide by 4, then saturated divide by 256
        bus.div_en = 1; bus.div_val = 2;
        cycle();
        load(1, 1, 32'h0);
        bus.timer_en = 1;
        cycle();
        repeat (16) cycle();
        check("t2_div4", bus.cnt_val, 64'd4);
        bus.timer_en = 0;
        cycle();
        bus.div_val = 12;
        cycle();
        load(1, 1, 32'h0);
        bus.timer_en = 1;
        cycle();
        repeat (255) cycle();
        check("t2_div256_pre", bus.cnt_val, 64'd0);
        cycle();
        check("t2_div256", bus.cnt_val, 64'd1);
        $display("T2 prescaled count=%0d", bus.cnt_val);

        // T3: wrap from all-ones
        bus.timer_en = 0;
        cycle();
        bus.div_en = 0;
        cycle();
        load(1, 1, 32'hFFFF_FFFF);
        check("t3_loaded", bus.cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.timer_en = 1;
        cycle();
        cycle();
        check("t3_wrap_cnt", bus.cnt_val, 64'd0);
        check("t3_wrap_ovf", bus.cnt_ovf, 64'd1);
        cycle();
        check("t3_ovf_pulse", bus.cnt_ovf, 64'd0);
        $display("T3 wrap count=%0d", bus.cnt_val);

        // T4: debug halt at count 7
        bus.timer_en = 0;
        cycle();
        load(1, 1, 32'h0);
        bus.timer_en = 1;
        cycle();
        repeat (7) cycle();
        check("t4_at7", bus.cnt_val, 64'd7);
        bus.dbg_mode = 1; bus.halt_req = 1;
        cycle();
        check("t4_ack", bus.halt_ack, 64'(HALT_EN));
        repeat (20) cycle();
        check("t4_frozen", bus.cnt_val, HALT_EN ? 64'd7 : 64'd28);
        bus.halt_req = 0;
        cycle();
        check("t4_release_ack", bus.halt_ack, 64'd0);
        repeat (2) cycle();
        check("t4_resume", bus.cnt_val, HALT_EN ? 64'd9 : 64'd31);
        $display("T4 halt count=%0d", bus.cnt_val);

        // T5: load with a tick due, downstream compare fires
        bus.timer_en = 0; bus.dbg_mode = 0;
        cycle();
        bus.div_en = 1; bus.div_val = 2; irq_clr = 1;
        cycle();
        irq_clr = 0;
        bus.timer_en = 1;
        cycle();
        repeat (3) cycle();
        load(1, 0, 32'h5);
        check("t5_load", bus.cnt_val, 64'd5);
        cycle();
        check("t5_irq", irq, 64'd1);
        repeat (2) cycle();
        check("t5_restart", bus.cnt_val, 64'd5);
        cycle();
        check("t5_next", bus.cnt_val, 64'd6);
        $display("T5 load count=%0d", bus.cnt_val);

        // T6: asynchronous reset mid-count
        bus.timer_en = 0;
        cycle();
        bus.div_en = 0;
        cycle();
        load(0, 1, 32'h0);
        load(1, 0, 32'h1230);
        bus.timer_en = 1;
        cycle();
        repeat (4) cycle();
        check("t6_at1234", bus.cnt_val, 64'h1234);
        bus.dbg_mode = 1; bus.halt_req = 1;
        cycle();
        #3 sys_rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_cnt", bus.cnt_val, m_cnt);
        check("t6_rst_ack", bus.halt_ack, 64'(m_ack));
        check("t6_rst_ovf", bus.cnt_ovf, 64'(m_ovf));
        bus.timer_en = 0; bus.dbg_mode = 0; bus.halt_req = 0;
        @(negedge sys_clk) sys_rst_n = 1'b1;
        $display("T6 reset count=%0d", bus.cnt_val);

        // Randomized traffic
        halt_left = 0;
        for (int i = 0; i < 3000; i++) begin
            bus.cnt_lo_we = 0; bus.cnt_hi_we = 0;
            if (halt_left == 0 && bus.timer_en && $urandom_range(40, 0) == 0)
                halt_left = $urandom_range(12, 1);
            if (halt_left > 0) begin
                halt_left--;
                bus.dbg_mode = 1; bus.halt_req = 1;
            end else begin
                bus.dbg_mode = 1'($urandom_range(1, 0)); bus.halt_req = 0;
                if ($urandom_range(15, 0) == 0) bus.timer_en = !bus.timer_en;
                if (m_state != 2 && $urandom_range(11, 0) == 0) begin
                    bus.cnt_lo_we = 1'($urandom_range(1, 0));
                    bus.cnt_hi_we = 1'($urandom_range(1, 0));
                    case ($urandom_range(3, 0))
                        0:       bus.wdata = 32'hFFFF_FFFF;
                        1:       bus.wdata = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
                        2:       bus.wdata = $urandom;
                        default: bus.wdata = 32'($urandom_range(20, 0));
                    endcase
                end
                if (!bus.timer_en && m_state == 0 && $urandom_range(3, 0) == 0) begin
                    bus.div_en  = 1'($urandom_range(1, 0));
                    bus.div_val = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 0))
                                                             : 4'($urandom_range(3, 0));
                end
            end
            cycle();
        end
        $display("Random phase done, final count=0x%0h", bus.cnt_val);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
